// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_ULT  = 4'd7;
   localparam logic [3:0] OP_LSL  = 4'd8;
   localparam logic [3:0] OP_LSR  = 4'd9;
   localparam logic [3:0] OP_ASR  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12;
   localparam logic [3:0] OP_REMU = 4'd13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic v;
      logic z;
      logic s;
      logic c;
      logic err;
      logic dz;
   } flags_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module seq_alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             div_q, div_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_diff;
   logic             rem_ge;

   // hi/lo are shared: product high/low half for MUL, remainder/quotient for DIV.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_shift = {hi_q, lo_q[WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, b_q});
      rem_diff  = rem_shift[WIDTH-1:0] - b_q;
      if (div_q) begin
         hi_nxt = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
         lo_nxt = {lo_q[WIDTH-2:0], rem_ge};
      end else begin
         hi_nxt = mul_sum[WIDTH:1];
         lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // done flags the cycle in which the final iteration is being computed.
   assign done = busy_q & (cnt_q == CNT_W'(1));
   assign hi   = hi_q;
   assign lo   = lo_q;

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      div_d  = div_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      b_d    = b_q;
      if (start && !busy_q) begin
         busy_d = 1'b1;
         cnt_d  = CNT_W'(WIDTH);
         div_d  = div_mode;
         hi_d   = '0;
         lo_d   = a;
         b_d    = b;
      end else if (busy_q) begin
         hi_d  = hi_nxt;
         lo_d  = lo_nxt;
         cnt_d = cnt_q - CNT_W'(1);
         if (done) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         div_q  <= div_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         b_q    <= b_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake on both sides and iterative MUL/DIVU/REMU.
//   state | meaning
//   IDLE  | ready for a request; single-cycle ops complete straight from here
//   ITER  | multiplier/divider iterating, request side stalled
//   DONE  | mul/div result ready but output register still occupied
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int TAG_W  = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             V,
   output logic             Z,
   output logic             S,
   output logic             C,
   output logic             err,
   output logic             dz,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             dz_q, dz_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   flags_t           flags_q, flags_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;

   logic [WIDTH:0]   add_sum, sub_diff;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] alu_res;
   flags_t           alu_flg;
   logic             is_multi;

   logic             md_start, md_done;
   logic [WIDTH-1:0] md_hi_nxt, md_lo_nxt, md_hi, md_lo;
   logic [WIDTH-1:0] src_hi, src_lo, md_res;
   flags_t           md_flg;

   logic             out_free, accept, wr_en;
   logic [WIDTH-1:0] wr_res;
   flags_t           wr_flg;
   logic [TAG_W-1:0] wr_tag;

   assign sh = y[SHW-1:0];

   always_comb begin
      add_sum  = {1'b0, x} + {1'b0, y};
      sub_diff = {1'b0, x} - {1'b0, y};
      alu_res  = '0;
      alu_flg  = '0;
      is_multi = 1'b0;
      case (ctrl)
         OP_ADD: begin
            alu_res   = add_sum[WIDTH-1:0];
            alu_flg.c = add_sum[WIDTH];
            alu_flg.v = (x[WIDTH-1] == y[WIDTH-1]) & (add_sum[WIDTH-1] != x[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = sub_diff[WIDTH-1:0];
            alu_flg.c = sub_diff[WIDTH];
            alu_flg.v = (x[WIDTH-1] != y[WIDTH-1]) & (sub_diff[WIDTH-1] != x[WIDTH-1]);
         end
         OP_AND: alu_res = x & y;
         OP_OR:  alu_res = x | y;
         OP_XOR: alu_res = x ^ y;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         OP_ULT: alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
         OP_LSL: alu_res = x << sh;
         OP_LSR: alu_res = x >> sh;
         OP_ASR: alu_res = $signed(x) >>> sh;
         OP_MUL, OP_DIVU, OP_REMU: begin
            if (MUL_EN) begin
               is_multi = 1'b1;
            end else begin
               alu_flg.err = 1'b1;
            end
         end
         default: alu_flg.err = 1'b1;
      endcase
      alu_flg.z = (alu_res == '0);
      alu_flg.s = alu_res[WIDTH-1];
   end

   seq_alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (md_start),
      .div_mode (ctrl != OP_MUL),
      .a        (x),
      .b        (y),
      .done     (md_done),
      .hi_nxt   (md_hi_nxt),
      .lo_nxt   (md_lo_nxt),
      .hi       (md_hi),
      .lo       (md_lo)
   );

   // In ITER the final iteration is taken straight from the iterator so the
   // result lands on the same edge the last bit is computed.
   always_comb begin
      src_hi    = (state_q == ITER) ? md_hi_nxt : md_hi;
      src_lo    = (state_q == ITER) ? md_lo_nxt : md_lo;
      md_res    = (op_q == OP_REMU) ? src_hi : src_lo;
      md_flg    = '0;
      md_flg.c  = (op_q == OP_MUL) & (|src_hi);
      md_flg.dz = dz_q;
      md_flg.z  = (md_res == '0);
      md_flg.s  = md_res[WIDTH-1];
   end

   assign out_free = ~out_valid_q | out_ready;
   assign in_ready = (state_q == IDLE) & out_free;
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      tag_d    = tag_q;
      dz_d     = dz_q;
      md_start = 1'b0;
      wr_en    = 1'b0;
      wr_res   = alu_res;
      wr_flg   = alu_flg;
      wr_tag   = in_tag;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_multi) begin
                  state_d  = ITER;
                  md_start = 1'b1;
                  op_d     = ctrl;
                  tag_d    = in_tag;
                  dz_d     = (ctrl != OP_MUL) && (y == '0);
               end else begin
                  wr_en = 1'b1;
               end
            end
         end
         ITER: begin
            if (md_done) begin
               wr_res = md_res;
               wr_flg = md_flg;
               wr_tag = tag_q;
               if (out_free) begin
                  wr_en   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            wr_res = md_res;
            wr_flg = md_flg;
            wr_tag = tag_q;
            if (out_free) begin
               wr_en   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = wr_en | (out_valid_q & ~out_ready);
      result_d    = wr_en ? wr_res : result_q;
      flags_d     = wr_en ? wr_flg : flags_q;
      out_tag_d   = wr_en ? wr_tag : out_tag_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         tag_q       <= '0;
         dz_q        <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         out_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         tag_q       <= tag_d;
         dz_q        <= dz_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign V         = flags_q.v;
   assign Z         = flags_q.z;
   assign S         = flags_q.s;
   assign C         = flags_q.c;
   assign err       = flags_q.err;
   assign dz        = flags_q.dz;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: behavioural reference with a per-cycle output/handshake checker.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  ctrl = '0;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic [3:0]  in_tag = '0;
   logic        in_ready, out_valid, V, Z, S, C, err, dz;
   logic [31:0] result;
   logic [3:0]  out_tag;

   logic        in_valid0 = 1'b0;
   logic        out_ready0 = 1'b1;
   logic        in_ready0, out_valid0, V0, Z0, S0, C0, err0, dz0;
   logic [31:0] result0;
   logic [3:0]  out_tag0;

   seq_alu #(.WIDTH(32), .TAG_W(4), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ctrl(ctrl), .x(x), .y(y), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .V(V), .Z(Z), .S(S), .C(C), .err(err), .dz(dz), .out_tag(out_tag));

   seq_alu #(.WIDTH(32), .TAG_W(4), .MUL_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .ctrl(ctrl), .x(x), .y(y), .in_tag(in_tag),
      .out_valid(out_valid0), .out_ready(out_ready0), .result(result0),
      .V(V0), .Z(Z0), .S(S0), .C(C0), .err(err0), .dz(dz0), .out_tag(out_tag0));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [31:0] res;
      logic        v, z, s, c, err, dz;
      logic [3:0]  tag;
      int          due;
   } exp_t;

   // Reference: results straight from integer arithmetic on 64-bit values.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] t);
      exp_t e;
      longint sa, sb, sr;
      longint unsigned ur;
      int sh;
      e = '0;
      e.tag = t;
      e.due = 1;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      case (op)
         4'd1: begin
            ur = {32'd0, a} + {32'd0, b};
            e.res = ur[31:0];
            e.c = (ur > 64'hFFFF_FFFF);
            sr = sa + sb;
            e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd2: begin
            e.res = a - b;
            e.c = (a < b);
            sr = sa - sb;
            e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd3: e.res = a & b;
         4'd4: e.res = a | b;
         4'd5: e.res = a ^ b;
         4'd6: e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd7: e.res = (a < b) ? 32'd1 : 32'd0;
         4'd8: e.res = a << sh;
         4'd9: e.res = a >> sh;
         4'd10: begin
            sr = sa >>> sh;
            e.res = sr[31:0];
         end
         4'd11: begin
            ur = {32'd0, a} * {32'd0, b};
            e.res = ur[31:0];
            e.c = (ur[63:32] != 32'd0);
            e.due = 33;
         end
         4'd12: begin
            e.due = 33;
            if (b == 32'd0) begin e.res = 32'hFFFF_FFFF; e.dz = 1'b1; end
            else e.res = a / b;
         end
         4'd13: begin
            e.due = 33;
            if (b == 32'd0) begin e.res = a; e.dz = 1'b1; end
            else e.res = a % b;
         end
         default: e.err = 1'b1;
      endcase
      e.z = (e.res == 32'd0);
      e.s = e.res[31];
      return e;
   endfunction

   exp_t q[$];
   exp_t cur;
   bit   mov = 1'b0;
   bit   mcons = 1'b0;

   always @(negedge clk) begin
      bit exp_ov, exp_rdy, newr;
      exp_t e;
      if (!rst_n) begin
         q.delete();
         mov = 1'b0;
         mcons = 1'b0;
      end else begin
         newr = (q.size() > 0) && (q[0].due == cyc);
         exp_ov = newr || (mov && !mcons);
         chk("mon_out_valid", out_valid, exp_ov);
         if (newr) cur = q.pop_front();
         if (exp_ov && out_valid) begin
            chk("mon_result", result, cur.res);
            chk("mon_flags_VZSC_err_dz", {V, Z, S, C, err, dz},
                {cur.v, cur.z, cur.s, cur.c, cur.err, cur.dz});
            chk("mon_tag", out_tag, cur.tag);
         end
         exp_rdy = (q.size() == 0) && (!exp_ov || out_ready);
         chk("mon_in_ready", in_ready, exp_rdy);
         if (in_valid && exp_rdy) begin
            e = model(ctrl, x, y, in_tag);
            e.due = cyc + e.due;
            q.push_back(e);
         end
         mov = exp_ov;
         mcons = exp_ov && out_ready;
      end
   end

   bit rand_ready = 1'b0;
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t);
      bit ok = 1'b0;
      ctrl = op; x = a; y = b; in_tag = t; in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      chk("accept_timeout", ok, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ctrl = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      in_tag = 4'($urandom_range(0, 15));
   endtask

   task automatic expect_out(input string nm, input logic [31:0] r, input logic [5:0] f,
                             input logic [3:0] t, input int lat);
      int n = 0;
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         n++;
         ok = out_valid;
      end
      chk({nm, "_valid"}, ok, 1);
      chk({nm, "_latency"}, n, lat);
      chk({nm, "_result"}, result, r);
      chk({nm, "_flags"}, {V, Z, S, C, err, dz}, f);
      chk({nm, "_tag"}, out_tag, t);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] edge_v [5];
   logic [31:0] held;

   initial begin
      logic [3:0] op;
      logic [31:0] a, b;
      edge_v = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {V, Z, S, C, err, dz}, 0);
      chk("rst_tag", out_tag, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      do_op(4'd1, 32'h7FFF_FFFF, 32'h1, 4'h1);
      expect_out("add_ovf", 32'h8000_0000, 6'b101000, 4'h1, 1);
      do_op(4'd2, 32'h0, 32'h1, 4'h2);
      expect_out("sub_borrow", 32'hFFFF_FFFF, 6'b001100, 4'h2, 1);
      do_op(4'd1, 32'hFFFF_FFFF, 32'h1, 4'h3);
      expect_out("add_carry", 32'h0, 6'b010100, 4'h3, 1);
      do_op(4'd11, 32'h0001_0000, 32'h0001_0000, 4'h4);
      expect_out("mul_hi", 32'h0, 6'b010100, 4'h4, 33);
      do_op(4'd12, 32'd100, 32'd7, 4'h5);
      expect_out("divu", 32'd14, 6'b000000, 4'h5, 33);
      do_op(4'd13, 32'd100, 32'd7, 4'h6);
      expect_out("remu", 32'd2, 6'b000000, 4'h6, 33);
      do_op(4'd12, 32'd5, 32'd0, 4'h7);
      expect_out("divu_dz", 32'hFFFF_FFFF, 6'b001001, 4'h7, 33);
      do_op(4'd13, 32'd5, 32'd0, 4'h8);
      expect_out("remu_dz", 32'd5, 6'b000001, 4'h8, 33);

      out_ready = 1'b0;
      do_op(4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h9);
      expect_out("bp_xor", 32'hFF00_FF00, 6'b001000, 4'h9, 1);
      held = result;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_result", result, held);
         chk("bp_hold_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_released", out_valid, 0);
      @(posedge clk);
      #1;

      do_op(4'hF, 32'h1234, 32'h5678, 4'hB);
      expect_out("illegal_f", 32'h0, 6'b010010, 4'hB, 1);
      do_op(4'h0, 32'h1, 32'h1, 4'hC);
      expect_out("illegal_0", 32'h0, 6'b010010, 4'hC, 1);

      ctrl = 4'd11; x = 32'd3; y = 32'd4; in_tag = 4'hD; in_valid0 = 1'b1;
      @(negedge clk);
      chk("m0_in_ready", in_ready0, 1);
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      @(negedge clk);
      chk("m0_valid", out_valid0, 1);
      chk("m0_result", result0, 0);
      chk("m0_flags", {V0, Z0, S0, C0, err0, dz0}, 6'b010010);
      chk("m0_tag", out_tag0, 4'hD);
      @(posedge clk);
      #1;

      do_op(4'd2, 32'h0, 32'h1, 4'h1);
      expect_out("pre_rst_sub", 32'hFFFF_FFFF, 6'b001100, 4'h1, 1);
      do_op(4'd12, 32'd1000, 32'd3, 4'h2);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_result", result, 0);
      chk("arst_flags", {V, Z, S, C, err, dz}, 0);
      chk("arst_tag", out_tag, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 4'hA);
      expect_out("asr_after_rst", 32'hFFFF_FFFF, 6'b001000, 4'hA, 1);

      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = 32'($urandom_range(0, 15)); b = 32'($urandom_range(0, 15)); end
            2: begin a = edge_v[$urandom_range(0, 4)]; b = edge_v[$urandom_range(0, 4)]; end
            default: begin a = $urandom; b = 32'd0; end
         endcase
         do_op(op, a, b, 4'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("drain_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
